shared_array_arbiter: RTL and testbench
=======================================

# shared_array_arbiter

Four-requester read front end for the shared 256×8 lookup array. Each core-side port issues byte reads; the block arbitrates one request per cycle onto the array's single address bus, samples the combinational data return, and delivers a registered response to the winning port. It sits directly upstream of the array, between the core load units and the array's address/data pins.

## Interface
- NPORTS, 4, number of requester ports (fixed at 4 in this revision)
- AW, 8, address width
- DW, 8, data width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  4  per-port read request
- req_addr  in  4×AW (packed, port i at [i*AW +: AW])  per-port read address
- req_ready  out  4  one-hot grant; request accepted when req_valid[i] && req_ready[i]
- rsp_valid  out  4  one-hot response strobe, one cycle per accepted request
- rsp_data  out  DW  response byte, valid for the port flagged in rsp_valid
- arr_addr  out  AW  address driven to the array
- arr_data  in  DW  combinational read data from the array
- busy  out  1  high when any req_valid is high or a response is pending

## Operation
- Cycle of acceptance (cycle T): arbiter picks one requesting port i, asserts req_ready[i] combinationally, drives arr_addr = req_addr[i]; arr_data sampled on the T clock edge into the response register.
- Cycle T+1: rsp_valid[i] = 1, rsp_data = sampled byte. No response backpressure; requester must take the byte in that cycle.
- Throughput: one accepted request per cycle, back-to-back across ports or from the same port.
- Requesters hold req_valid and req_addr stable until accepted; withdrawing before acceptance is legal and leaves no trace.
- Arbitration (default round-robin): 2-bit pointer ptr; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); first requester wins. After a grant to port i, ptr <= i+1 (mod 4). No grant leaves ptr unchanged.
- When no port requests: req_ready = 0, arr_addr holds last granted address (no toggle), rsp_valid next cycle = 0.
- Response state: rsp_port (2 bits) and rsp_pend (1 bit) registers; rsp_valid = rsp_pend ? onehot(rsp_port) : 0.

## Timing
- Reset (reset low, async): req_ready = 0, rsp_valid = 0, rsp_data = 0, arr_addr = 0, busy = 0, ptr = 0, rsp_pend = 0. Release synchronised by the system; block acts on first rising edge after release.
- Reset asserted while a response is pending: response dropped, no rsp_valid after release.
- Read latency: 1 cycle from acceptance to rsp_valid.
- Simultaneous all-four requests held continuously: grants rotate 0,1,2,3,0,…; each port served once every 4 cycles (max wait 3 cycles).
- ptr wrap: grant to port 3 sets ptr = 0.
- Address wrap not applicable: full AW range valid, 0xFF and 0x00 behave identically to any other address.
- busy is combinational OR of req_valid and rsp_pend.

## Configuration
- ARB_FIXED_PRIO_EN defined: fixed priority, port 0 highest, port 3 lowest; ptr register removed; continuous port-0 requests starve others (documented, intended for debug/single-core bring-up).
- Not defined: round-robin as above.

## Structure
- Shared package: NPORTS, AW, DW constants and the one-hot/index conversion function (onehot-to-index, index-to-onehot).
- One sub-module: rr_arbiter4 (request vector + ptr in, one-hot grant out, next-ptr out); the ARB_FIXED_PRIO_EN variant lives inside it. Response register and mux in the top.

## Test plan
- Reset: hold reset low mid-stream with rsp_pend = 1 -> all outputs 0, no rsp_valid after release.
- Single port: port 2 requests addr 0x5A at T -> req_ready = 4'b0100 at T, rsp_valid = 4'b0100, rsp_data = 0x5A at T+1 (identity-loaded array).
- Back-to-back same port: port 0 reads 0x00, 0xFF, 0x80 on consecutive cycles -> responses 0x00, 0xFF, 0x80 on consecutive cycles, no bubbles.
- Fairness: all four request continuously from ptr = 0 for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each rsp_data equals that port's address.
- Pointer skip/wrap: ports 1 and 3 request, ptr = 2 -> port 3 granted, ptr becomes 0; next cycle port 1 granted.
- ARB_FIXED_PRIO_EN build: ports 0 and 2 request continuously for 5 cycles -> port 0 granted every cycle, port 2 never; drop port 0 -> port 2 granted next cycle.

Source files
------------

// File: rtl/shared_array_arbiter_pkg.sv
// Shared constants and one-hot/index helpers for the shared-array read front end.
// Used by shared_array_arbiter and rr_arbiter4.
package shared_array_arbiter_pkg;

  localparam int NPORTS = 4;
  localparam int IW     = 2;
  localparam int AW     = 8;
  localparam int DW     = 8;

  function automatic logic [NPORTS-1:0] idx2oh(input logic [IW-1:0] idx);
    logic [NPORTS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Assumes at most one bit set; an all-zero vector maps to index 0.
  function automatic logic [IW-1:0] oh2idx(input logic [NPORTS-1:0] oh);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (oh[i]) idx = idx | IW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way combinational arbiter: round-robin from ptr, or fixed priority (port 0 highest)
// when ARB_FIXED_PRIO_EN is defined. Zero latency; ptr_nxt equals ptr when nothing is granted.
module rr_arbiter4
  import shared_array_arbiter_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [NPORTS-1:0] gnt,
  output logic [IW-1:0]     ptr_nxt
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Isolate the lowest set request bit.
  assign gnt     = req & ~(req - NPORTS'(1));
  assign ptr_nxt = ptr;
`else
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    idx     = '0;
    ptr_nxt = ptr;
    for (int k = 0; k < NPORTS; k++) begin
      idx = ptr + IW'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        ptr_nxt  = idx + IW'(1);
      end
    end
  end
`endif

endmodule

// File: rtl/shared_array_arbiter.sv
// Four-port byte-read front end for the 256x8 shared array: one grant per cycle, response 1 cycle later.
// No response backpressure; requesters hold until req_ready. Fixed priority under ARB_FIXED_PRIO_EN.
module shared_array_arbiter
  import shared_array_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    req_valid,
  input  logic [NPORTS*AW-1:0] req_addr,
  output logic [NPORTS-1:0]    req_ready,
  output logic [NPORTS-1:0]    rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic [AW-1:0]        arr_addr,
  input  logic [DW-1:0]        arr_data,
  output logic                 busy
);

  logic [NPORTS-1:0] arb_gnt;
  logic [NPORTS-1:0] gnt;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_any;
  logic [IW-1:0]     arb_ptr;
  logic [IW-1:0]     ptr_nxt;

  logic [AW-1:0] last_addr_q, last_addr_d;
  logic          rsp_pend_q,  rsp_pend_d;
  logic [IW-1:0] rsp_port_q,  rsp_port_d;
  logic [DW-1:0] rsp_data_q,  rsp_data_d;

`ifdef ARB_FIXED_PRIO_EN
  logic unused_ptr_nxt;
  assign arb_ptr        = '0;
  assign unused_ptr_nxt = ^ptr_nxt;
`else
  logic [IW-1:0] ptr_q, ptr_d;
  assign arb_ptr = ptr_q;
  assign ptr_d   = ptr_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  rr_arbiter4 u_arb (
    .req     (req_valid),
    .ptr     (arb_ptr),
    .gnt     (arb_gnt),
    .ptr_nxt (ptr_nxt)
  );

  // The grant path is combinational, so it must be masked while reset is held.
  assign gnt     = arb_gnt & {NPORTS{reset}};
  assign gnt_any = |gnt;
  assign gnt_idx = oh2idx(gnt);

  always_comb begin
    arr_addr    = last_addr_q;
    if (gnt_any) arr_addr = req_addr[gnt_idx*AW +: AW];
    last_addr_d = arr_addr;
    rsp_pend_d  = gnt_any;
    rsp_port_d  = gnt_any ? gnt_idx  : rsp_port_q;
    rsp_data_d  = gnt_any ? arr_data : rsp_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_addr_q <= '0;
      rsp_pend_q  <= 1'b0;
      rsp_port_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      last_addr_q <= last_addr_d;
      rsp_pend_q  <= rsp_pend_d;
      rsp_port_q  <= rsp_port_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rsp_pend_q ? idx2oh(rsp_port_q) : '0;
  assign rsp_data  = rsp_data_q;
  assign busy      = reset & ((|req_valid) | rsp_pend_q);

endmodule

// File: tb/tb_shared_array_arbiter.sv
// Randomized self-checking bench for shared_array_arbiter against a cycle-level reference model.
module tb_shared_array_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic [7:0]  arr_addr;
  logic [7:0]  arr_data;
  logic        busy;

  logic [7:0] mem [256];
  assign arr_data = mem[arr_addr];

  int checks = 0;
  int errors = 0;

  shared_array_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .arr_addr  (arr_addr),
    .arr_data  (arr_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int         m_ptr;
  bit         m_pend;
  int         m_port;
  logic [7:0] m_data;
  logic [7:0] m_last;
  // Expected values for the current cycle
  int         e_win;
  logic [3:0] e_gnt;
  logic [7:0] e_addr;
  logic [3:0] e_rsp_v;
  logic [7:0] e_rsp_d;
  logic       e_busy;

  function automatic void model_reset();
    m_ptr  = 0;
    m_pend = 0;
    m_port = 0;
    m_data = 8'h00;
    m_last = 8'h00;
  endfunction

  function automatic void model_eval();
    int start;
`ifdef ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    e_win = -1;
    for (int k = 0; k < 4; k++) begin
      int p;
      p = (start + k) % 4;
      if (e_win < 0 && req_valid[p]) e_win = p;
    end
    e_gnt   = (e_win < 0) ? 4'b0000 : 4'(1 << e_win);
    e_addr  = (e_win < 0) ? m_last : req_addr[e_win*8 +: 8];
    e_busy  = (req_valid != 4'b0000) || m_pend;
    e_rsp_v = m_pend ? 4'(1 << m_port) : 4'b0000;
    e_rsp_d = m_data;
  endfunction

  // Commit one clock edge to the model and the DUT; returns at posedge + 1.
  task automatic tick();
    model_eval();
    if (e_win >= 0) begin
      m_pend = 1;
      m_port = e_win;
      m_data = mem[e_addr];
      m_last = e_addr;
      m_ptr  = (e_win + 1) % 4;
    end else begin
      m_pend = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req_valid = 4'b0000;
    reset     = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = 4'b1111;
    req_addr  = $urandom;
    model_reset();
    #3;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h exp 00", rsp_data); end
    checks++; if (arr_addr !== 8'h00) begin errors++; $display("FAIL reset_arr_addr got %h exp 00", arr_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = 4'b0010;
    req_addr  = 32'h0000_3300;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL reset_first_gnt got %b exp 0010", req_ready); end
    tick();
    // Response is now pending; reset mid-cycle must drop it.
    req_valid = 4'b0000;
    reset     = 1'b0;
    model_reset();
    #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_mid_rsp_valid got %b exp 0000", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_mid_rsp_data got %h exp 00", rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got %b exp 0", busy); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_after_rsp_valid got %b exp 0000", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_after2_rsp_valid got %b exp 0000", rsp_valid); end
  endtask

  task automatic test_single();
    req_valid         = 4'b0100;
    req_addr[16 +: 8] = 8'h5A;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp 0100", req_ready); end
    checks++; if (arr_addr !== 8'h5A) begin errors++; $display("FAIL single_arr_addr got %h exp 5a", arr_addr); end
    tick();
    req_valid = 4'b0000;
    #1;
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid got %b exp 0100", rsp_valid); end
    checks++; if (rsp_data !== 8'h5A) begin errors++; $display("FAIL single_rsp_data got %h exp 5a", rsp_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3];
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h80;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        req_valid        = 4'b0001;
        req_addr[0 +: 8] = seq[i];
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      if (i < 3) begin
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL b2b_gnt[%0d] got %b exp 0001", i, req_ready); end
      end
      if (i > 0) begin
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL b2b_rsp_valid[%0d] got %b exp 0001", i, rsp_valid); end
        checks++; if (rsp_data !== seq[i-1]) begin errors++; $display("FAIL b2b_rsp_data[%0d] got %h exp %h", i, rsp_data, seq[i-1]); end
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_gnt;
    logic [7:0] exp_d;
    int         prev;
    apply_reset();
    req_addr  = $urandom;
    req_valid = 4'b1111;
    prev      = -1;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) req_valid = 4'b0000;
      #1;
`ifdef ARB_FIXED_PRIO_EN
      exp_gnt = 4'b0001;
`else
      exp_gnt = 4'(1 << (i % 4));
`endif
      if (i < 8) begin
        checks++; if (req_ready !== exp_gnt) begin errors++; $display("FAIL fair_gnt[%0d] got %b exp %b", i, req_ready, exp_gnt); end
      end
      if (prev >= 0) begin
        exp_d = req_addr[prev*8 +: 8];
        checks++; if (rsp_data !== exp_d) begin errors++; $display("FAIL fair_rsp_data[%0d] got %h exp %h", i, rsp_data, exp_d); end
      end
      prev = (i < 8) ? ((exp_gnt == 4'b0001) ? 0 : (exp_gnt == 4'b0010) ? 1 : (exp_gnt == 4'b0100) ? 2 : 3) : -1;
      tick();
    end
  endtask

  task automatic test_ptr_wrap();
    logic [3:0] exp_gnt;
    apply_reset();
    req_addr  = 32'hC3_00_B1_00;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1010;
    #1;
`ifdef ARB_FIXED_PRIO_EN
    exp_gnt = 4'b0010;
`else
    exp_gnt = 4'b1000;
`endif
    checks++; if (req_ready !== exp_gnt) begin errors++; $display("FAIL wrap_gnt got %b exp %b", req_ready, exp_gnt); end
    tick();
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_next_gnt got %b exp 0010", req_ready); end
    model_eval();
    checks++; if (rsp_valid !== e_rsp_v) begin errors++; $display("FAIL wrap_rsp_valid got %b exp %b", rsp_valid, e_rsp_v); end
    tick();
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_priority();
    req_addr  = 32'h00_44_00_11;
    req_valid = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      #1;
      model_eval();
      checks++; if (req_ready !== e_gnt) begin errors++; $display("FAIL prio_gnt[%0d] got %b exp %b", i, req_ready, e_gnt); end
`ifdef ARB_FIXED_PRIO_EN
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL prio_fixed_gnt[%0d] got %b exp 0001", i, req_ready); end
`endif
      tick();
    end
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL prio_drop_gnt got %b exp 0100", req_ready); end
    tick();
  endtask

  task automatic test_idle();
    req_valid = 4'b0000;
    #1;
    model_eval();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL idle_gnt got %b exp 0000", req_ready); end
    checks++; if (arr_addr !== 8'h44) begin errors++; $display("FAIL idle_arr_addr got %h exp 44", arr_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL idle_busy_pend got %b exp 1", busy); end
    tick();
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL idle_rsp_valid got %b exp 0000", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
    checks++; if (arr_addr !== 8'h44) begin errors++; $display("FAIL idle_hold_addr got %h exp 44", arr_addr); end
  endtask

  task automatic test_random();
    logic [3:0] acc;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 4; p++) begin
        if (!req_valid[p]) begin
          if ($urandom_range(1, 0) == 1) begin
            req_valid[p]       = 1'b1;
            req_addr[p*8 +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(7, 0) == 0) begin
          req_valid[p] = 1'b0;
        end
      end
      #1;
      model_eval();
      checks++; if (req_ready !== e_gnt) begin errors++; $display("FAIL rnd_gnt[%0d] got %b exp %b", c, req_ready, e_gnt); end
      checks++; if (arr_addr !== e_addr) begin errors++; $display("FAIL rnd_arr_addr[%0d] got %h exp %h", c, arr_addr, e_addr); end
      checks++; if (rsp_valid !== e_rsp_v) begin errors++; $display("FAIL rnd_rsp_valid[%0d] got %b exp %b", c, rsp_valid, e_rsp_v); end
      checks++; if (rsp_data !== e_rsp_d) begin errors++; $display("FAIL rnd_rsp_data[%0d] got %h exp %h", c, rsp_data, e_rsp_d); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy[%0d] got %b exp %b", c, busy, e_busy); end
      acc = e_gnt;
      tick();
      req_valid = req_valid & ~acc;
    end
    req_valid = 4'b0000;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    req_valid = 4'b0000;
    req_addr  = 32'h0;
    reset     = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_ptr_wrap();
    test_priority();
    test_idle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
